ms_riscv32_mp_dmem_slave: RTL and testbench
===========================================

MS_RISCV32_MP_DMEM_SLAVE -- requirements
Module: ms_riscv32_mp_dmem_slave

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024: number of 32-bit words in the backing array.
REQ-002 SHALL have parameter BASE_ADDR, default 32'h0000_0000: byte address of word 0, aligned to DEPTH_WORDS*4.
REQ-003 SHALL have parameter WAIT_STATES, default 1, range 0..7: hready-low cycles per OKAY data phase.
REQ-004 SHALL have one clock and one reset, with reset asynchronous and active-low.
REQ-005 ms_riscv32_mp_clk_in  in  1  clock, all state rising-edge.
REQ-006 ms_riscv32_mp_rst_in  in  1  async active-low reset.
REQ-007 ms_riscv32_mp_data_htrans_in  in  2  transfer type: 0 IDLE, 1 BUSY, 2 NONSEQ, 3 SEQ.
REQ-008 ms_riscv32_mp_dmaddr_in  in  32  byte address, address phase.
REQ-009 ms_riscv32_mp_dmwr_req_in  in  1  1 = write, 0 = read, address phase.
REQ-010 ms_riscv32_mp_dmwr_mask_in  in  4  byte lanes, address phase.
REQ-011 ms_riscv32_mp_dmdata_in  in  32  write data, data phase.
REQ-012 ms_riscv32_mp_hready_out  out  1  data phase complete.
REQ-013 ms_riscv32_mp_hresp_out  out  1  1 = ERROR.
REQ-014 ms_riscv32_mp_dmdata_out  out  32  read data, valid only in the completing OKAY read cycle.

Function
REQ-015 SHALL capture address, wr_req and mask only on a clock edge where hready_out=1 and htrans is 2 or 3.
REQ-016 On htrans 0 or 1, SHALL give a zero-wait OKAY response with no array access.
REQ-017 SHALL run FSM states IDLE, WAIT, LAST, ERR1 and ERR2.
  - IDLE: hready=1, hresp=0.
  - WAIT: hready=0, hresp=0.
  - LAST: hready=1, hresp=0.
  - ERR1: hready=0, hresp=1.
  - ERR2: hready=1, hresp=1.
REQ-018 On a valid capture, SHALL transition as follows.
  - Error: go to ERR1.
  - Else, WAIT_STATES=0: go to LAST.
  - Else: go to WAIT and load the 3-bit counter with WAIT_STATES.
REQ-019 In WAIT, SHALL decrement the counter each cycle and go to LAST when the counter equals 1.
REQ-020 SHALL always go from ERR1 to ERR2.
REQ-021 LAST and ERR2 SHALL accept a new capture (pipelined) per REQ-018, and SHALL otherwise go to IDLE.
REQ-022 SHALL flag an error when either of these holds.
  - Address lies outside BASE_ADDR .. BASE_ADDR+DEPTH_WORDS*4-1.
  - Mask is not one of 0001, 0010, 0100, 1000, 0011, 1100, 1111.
REQ-023 Reads SHALL return the full word (lane selection is the master's job); dmdata_out SHALL be 0 in every cycle other than LAST-of-read.
REQ-024 In LAST-of-write, SHALL write dmdata_in to the array at the clock edge, enabled only for mask lanes.
REQ-025 An errored write SHALL never modify the array.
REQ-026 SHALL read the array combinationally from the captured word index, so a read whose data phase follows a write to the same word returns the new data with no forwarding.
REQ-027 SHALL use word index = (addr - BASE_ADDR) >> 2, width clog2(DEPTH_WORDS); addr[1:0] is ignored beyond the mask check.

Reset
REQ-028 While rst_in=0, SHALL hold state IDLE, counter 0, hready_out=1, hresp_out=0 and dmdata_out=0.
REQ-029 Reset asserted mid-transfer SHALL abort the transfer with no array write.
REQ-030 Array contents SHALL NOT be reset.

Structure
REQ-031 Package ms_riscv32_mp_dmem_pkg SHALL hold the htrans encodings, the FSM state enum and the legal-mask constants.
REQ-032 The storage SHALL be sub-module ms_riscv32_mp_dmem_array: DEPTH_WORDS x 32 register array, async read, sync write with 4 byte enables.

Verification
REQ-033 WAIT_STATES=1: write 0x1000 mask 1111 data 0xDEADBEEF, then read 0x1000 -> hready low 1 cycle each, read returns 0xDEADBEEF, hresp=0.
REQ-034 WAIT_STATES=0: back-to-back NONSEQ write 0x0008 mask 0010 data 0x0000AB00, then read 0x0008 over a word previously 0x11223344 -> next-cycle read 0x1122AB44.
REQ-035 Read at BASE_ADDR+DEPTH_WORDS*4 -> ERR1 (hready=0, hresp=1) then ERR2 (hready=1, hresp=1); dmdata_out=0.
REQ-036 Write with mask 0110 to 0x0004 holding 0x55555555 -> ERROR two-cycle response; later read of 0x0004 returns 0x55555555.
REQ-037 WAIT_STATES=3: assert rst_in=0 during WAIT of write 0x0010 data 0xFFFFFFFF over 0 -> outputs at reset values at once; later read of 0x0010 returns 0.
REQ-038 htrans=BUSY, then IDLE, for 3 cycles -> hready=1, hresp=0, no array change.

Source files
------------

// File: rtl/ms_riscv32_mp_dmem_pkg.sv
// Shared definitions for the RISC-V data-memory AHB-lite style slave.
//   - htrans_e : bus transfer type encodings
//   - state_e  : data-phase FSM states
//   - LEGAL_MASKS / mask_is_legal : byte-lane patterns the slave accepts
//     (single byte, aligned halfword, full word)
package ms_riscv32_mp_dmem_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'd0,
    HTRANS_BUSY   = 2'd1,
    HTRANS_NONSEQ = 2'd2,
    HTRANS_SEQ    = 2'd3
  } htrans_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_LAST,
    ST_ERR1,
    ST_ERR2
  } state_e;

  localparam int NUM_LEGAL_MASKS = 7;
  localparam logic [NUM_LEGAL_MASKS-1:0][3:0] LEGAL_MASKS = {
    4'b1111, 4'b1100, 4'b0011, 4'b1000, 4'b0100, 4'b0010, 4'b0001
  };

  function automatic logic mask_is_legal(input logic [3:0] mask);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < NUM_LEGAL_MASKS; i++) begin
      if (mask == LEGAL_MASKS[i]) hit = 1'b1;
    end
    return hit;
  endfunction

endpackage

// File: rtl/ms_riscv32_mp_dmem_slave_if.sv
// Bus bundle between the core's data-memory master and the memory slave.
//   master modport: drives htrans, address, write request, lane mask and write data;
//                   receives hready, hresp and read data.
//   slave modport : the reverse.
interface ms_riscv32_mp_dmem_slave_if;
  logic [1:0]  ms_riscv32_mp_data_htrans_in;
  logic [31:0] ms_riscv32_mp_dmaddr_in;
  logic        ms_riscv32_mp_dmwr_req_in;
  logic [3:0]  ms_riscv32_mp_dmwr_mask_in;
  logic [31:0] ms_riscv32_mp_dmdata_in;
  logic        ms_riscv32_mp_hready_out;
  logic        ms_riscv32_mp_hresp_out;
  logic [31:0] ms_riscv32_mp_dmdata_out;

  modport master (
    output ms_riscv32_mp_data_htrans_in, ms_riscv32_mp_dmaddr_in,
           ms_riscv32_mp_dmwr_req_in, ms_riscv32_mp_dmwr_mask_in,
           ms_riscv32_mp_dmdata_in,
    input  ms_riscv32_mp_hready_out, ms_riscv32_mp_hresp_out,
           ms_riscv32_mp_dmdata_out
  );

  modport slave (
    input  ms_riscv32_mp_data_htrans_in, ms_riscv32_mp_dmaddr_in,
           ms_riscv32_mp_dmwr_req_in, ms_riscv32_mp_dmwr_mask_in,
           ms_riscv32_mp_dmdata_in,
    output ms_riscv32_mp_hready_out, ms_riscv32_mp_hresp_out,
           ms_riscv32_mp_dmdata_out
  );
endinterface

// File: rtl/ms_riscv32_mp_dmem_array.sv
// Word-organised storage for the data-memory slave.
//   clk   : write clock
//   idx   : word index, shared by read and write
//   we/be : write enable and per-byte lane enables
//   wdata : write word
//   rdata : combinational read of word idx
module ms_riscv32_mp_dmem_array #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned IDX_W       = 10
) (
  input  logic             clk,
  input  logic [IDX_W-1:0] idx,
  input  logic             we,
  input  logic [3:0]       be,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  // NOTE: storage has no reset branch; contents survive reset and a reset
  // loop over the whole array would turn it into a huge reset network.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/ms_riscv32_mp_dmem_slave.sv
// Data-memory slave for the RISC-V core: AHB-lite style address/data pipeline
// with a configurable number of wait states and a two-cycle ERROR response.
//   ms_riscv32_mp_clk_in : clock, rising edge
//   ms_riscv32_mp_rst_in : asynchronous active-low reset
//   dmem                 : bus bundle (slave side)
// Parameters: DEPTH_WORDS (array size), BASE_ADDR (byte address of word 0),
// WAIT_STATES (0..7 hready-low cycles per OKAY data phase).
module ms_riscv32_mp_dmem_slave
  import ms_riscv32_mp_dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_STATES = 1
) (
  input logic                       ms_riscv32_mp_clk_in,
  input logic                       ms_riscv32_mp_rst_in,
  ms_riscv32_mp_dmem_slave_if.slave dmem
);

  localparam int unsigned IDX_W      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [32:0] SPAN_BYTES = 33'(DEPTH_WORDS) << 2;
  localparam logic [2:0]  WS_LOAD    = 3'(WAIT_STATES);

  state_e           state_q, state_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q;
  logic             wr_q;
  logic [3:0]       mask_q;

  logic        hready, hresp, capture, in_range, req_err, wr_en;
  logic [31:0] offset, rd_word;

  assign hready = (state_q == ST_IDLE) || (state_q == ST_LAST) || (state_q == ST_ERR2);
  assign hresp  = (state_q == ST_ERR1) || (state_q == ST_ERR2);

  // Address phase is only accepted while the previous data phase is completing.
  assign capture = hready &&
                   ((dmem.ms_riscv32_mp_data_htrans_in == HTRANS_NONSEQ) ||
                    (dmem.ms_riscv32_mp_data_htrans_in == HTRANS_SEQ));

  // Addresses below BASE_ADDR wrap to a huge offset and fail the same compare.
  assign offset   = dmem.ms_riscv32_mp_dmaddr_in - BASE_ADDR;
  assign in_range = {1'b0, offset} < SPAN_BYTES;
  assign req_err  = !in_range || !mask_is_legal(dmem.ms_riscv32_mp_dmwr_mask_in);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_in) begin
    if (!ms_riscv32_mp_rst_in) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      wr_q    <= 1'b0;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (capture) begin
        idx_q  <= offset[IDX_W+1:2];
        wr_q   <= dmem.ms_riscv32_mp_dmwr_req_in;
        mask_q <= dmem.ms_riscv32_mp_dmwr_mask_in;
      end
    end
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: state_d = ST_IDLE;
      ST_WAIT: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) state_d = ST_LAST;
      end
      ST_LAST: state_d = ST_IDLE;
      ST_ERR1: state_d = ST_ERR2;
      ST_ERR2: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    // capture can only be true in IDLE/LAST/ERR2, so this override is the
    // pipelined hand-over to the next data phase.
    if (capture) begin
      if (req_err) begin
        state_d = ST_ERR1;
      end else if (WAIT_STATES == 0) begin
        state_d = ST_LAST;
      end else begin
        state_d = ST_WAIT;
        cnt_d   = WS_LOAD;
      end
    end
  end

  // Errored transfers never reach LAST, so they can never write the array.
  assign wr_en = (state_q == ST_LAST) && wr_q;

  ms_riscv32_mp_dmem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (IDX_W)
  ) u_array (
    .clk   (ms_riscv32_mp_clk_in),
    .idx   (idx_q),
    .we    (wr_en),
    .be    (mask_q),
    .wdata (dmem.ms_riscv32_mp_dmdata_in),
    .rdata (rd_word)
  );

  assign dmem.ms_riscv32_mp_hready_out = hready;
  assign dmem.ms_riscv32_mp_hresp_out  = hresp;
  assign dmem.ms_riscv32_mp_dmdata_out = ((state_q == ST_LAST) && !wr_q) ? rd_word : 32'h0;

endmodule

// File: tb/tb_ms_riscv32_mp_dmem_slave.sv
// Self-checking bench: three slaves (WAIT_STATES 1, 0, 3) against a
// transaction-level memory/response model.
module tb_ms_riscv32_mp_dmem_slave;
  import ms_riscv32_mp_dmem_pkg::*;

  localparam int          TB_DEPTH  = 2048;
  localparam logic [31:0] TB_BASE   = 32'h0000_0000;
  localparam int          WIN_WORDS = 16;

  logic             clk;
  logic [2:0]       rst_n;
  logic [2:0][1:0]  htrans;
  logic [2:0][31:0] addr;
  logic [2:0]       wr;
  logic [2:0][3:0]  mask;
  logic [2:0][31:0] wdata;
  logic [2:0]       hready, hresp;
  logic [2:0][31:0] rdata;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] model [3][TB_DEPTH];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int WS = (g == 0) ? 1 : (g == 1) ? 0 : 3;
    ms_riscv32_mp_dmem_slave_if u_if ();
    assign u_if.ms_riscv32_mp_data_htrans_in = htrans[g];
    assign u_if.ms_riscv32_mp_dmaddr_in      = addr[g];
    assign u_if.ms_riscv32_mp_dmwr_req_in    = wr[g];
    assign u_if.ms_riscv32_mp_dmwr_mask_in   = mask[g];
    assign u_if.ms_riscv32_mp_dmdata_in      = wdata[g];
    assign hready[g] = u_if.ms_riscv32_mp_hready_out;
    assign hresp[g]  = u_if.ms_riscv32_mp_hresp_out;
    assign rdata[g]  = u_if.ms_riscv32_mp_dmdata_out;
    ms_riscv32_mp_dmem_slave #(
      .DEPTH_WORDS (TB_DEPTH),
      .BASE_ADDR   (TB_BASE),
      .WAIT_STATES (WS)
    ) u_dut (
      .ms_riscv32_mp_clk_in (clk),
      .ms_riscv32_mp_rst_in (rst_n[g]),
      .dmem                 (u_if.slave)
    );
  end

  // ---------------- reference model ----------------
  function automatic int ws_of(input int i);
    return (i == 0) ? 1 : (i == 1) ? 0 : 3;
  endfunction

  function automatic bit addr_ok(input logic [31:0] a);
    return (longint'(a) >= longint'(TB_BASE)) &&
           (longint'(a) < longint'(TB_BASE) + longint'(TB_DEPTH) * 4);
  endfunction

  function automatic bit mask_ok(input logic [3:0] m);
    case (m)
      4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic int word_of(input logic [31:0] a);
    return int'((a - TB_BASE) >> 2);
  endfunction

  function automatic void model_write(input int i, input int w, input logic [3:0] m,
                                      input logic [31:0] d);
    for (int b = 0; b < 4; b++) begin
      if (m[b]) model[i][w][8*b +: 8] = d[8*b +: 8];
    end
  endfunction

  // One isolated transfer with per-cycle checks of the data phase.
  task automatic xfer(input int i, input logic [31:0] a, input logic w,
                      input logic [3:0] m, input logic [31:0] d, input string tag);
    bit err;
    int exp_low;
    int low;
    bit done;
    logic [31:0] exp_rd;
    err     = !addr_ok(a) || !mask_ok(m);
    exp_low = err ? 1 : ws_of(i);
    @(negedge clk);
    htrans[i] = HTRANS_NONSEQ; addr[i] = a; wr[i] = w; mask[i] = m;
    @(negedge clk);
    htrans[i] = HTRANS_IDLE; wdata[i] = d; addr[i] = $urandom; wr[i] = ~w;
    low  = 0;
    done = 1'b0;
    for (int c = 0; c < 12 && !done; c++) begin
      if (hready[i]) begin
        done = 1'b1;
      end else begin
        low++;
        n_checks++;
        if (hresp[i] !== err || rdata[i] !== 32'h0) begin
          n_fail++;
          $display("FAIL %s: stall cycle hresp=%0b rdata=%08h, expected hresp=%0b rdata=00000000",
                   tag, hresp[i], rdata[i], err);
        end
        @(negedge clk);
      end
    end
    n_checks++;
    if (!done) begin
      n_fail++;
      $display("FAIL %s: hready never returned high within 12 cycles", tag);
    end else begin
      exp_rd = (err || w) ? 32'h0 : model[i][word_of(a)];
      n_checks++;
      if (low != exp_low) begin
        n_fail++;
        $display("FAIL %s: hready-low cycles=%0d expected=%0d", tag, low, exp_low);
      end
      n_checks++;
      if (hresp[i] !== err) begin
        n_fail++;
        $display("FAIL %s: completing hresp=%0b expected=%0b", tag, hresp[i], err);
      end
      n_checks++;
      if (rdata[i] !== exp_rd) begin
        n_fail++;
        $display("FAIL %s: completing rdata=%08h expected=%08h", tag, rdata[i], exp_rd);
      end
    end
    if (!err && w) model_write(i, word_of(a), m, d);
  endtask

  // Write immediately followed by a pipelined read of the same word (WAIT_STATES=0 slave).
  task automatic b2b(input logic [31:0] a, input logic [3:0] m, input logic [31:0] d,
                     input bit use_seq, input string tag);
    logic [31:0] exp_rd;
    @(negedge clk);
    htrans[1] = HTRANS_NONSEQ; addr[1] = a; wr[1] = 1'b1; mask[1] = m;
    @(negedge clk);
    n_checks++;
    if (hready[1] !== 1'b1 || hresp[1] !== 1'b0 || rdata[1] !== 32'h0) begin
      n_fail++;
      $display("FAIL %s: write phase hready=%0b hresp=%0b rdata=%08h, expected 1/0/00000000",
               tag, hready[1], hresp[1], rdata[1]);
    end
    htrans[1] = use_seq ? HTRANS_SEQ : HTRANS_NONSEQ;
    addr[1]   = {a[31:2], 2'($urandom)};
    wr[1]     = 1'b0;
    mask[1]   = 4'b1111;
    wdata[1]  = d;
    model_write(1, word_of(a), m, d);
    exp_rd = model[1][word_of(a)];
    @(negedge clk);
    htrans[1] = HTRANS_IDLE; wdata[1] = $urandom;
    n_checks++;
    if (hready[1] !== 1'b1 || hresp[1] !== 1'b0 || rdata[1] !== exp_rd) begin
      n_fail++;
      $display("FAIL %s: read phase hready=%0b hresp=%0b rdata=%08h, expected 1/0/%08h",
               tag, hready[1], hresp[1], rdata[1], exp_rd);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = '0;
    for (int i = 0; i < 3; i++) begin
      htrans[i] = HTRANS_NONSEQ; addr[i] = 32'h0; wr[i] = 1'b1;
      mask[i] = 4'b1111; wdata[i] = $urandom;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (hready[i] !== 1'b1 || hresp[i] !== 1'b0 || rdata[i] !== 32'h0) begin
        n_fail++;
        $display("FAIL reset[%0d]: hready=%0b hresp=%0b rdata=%08h, expected 1/0/00000000",
                 i, hready[i], hresp[i], rdata[i]);
      end
      htrans[i] = HTRANS_IDLE;
    end
    @(negedge clk);
    rst_n = '1;
  endtask

  task automatic test_fill();
    for (int i = 0; i < 3; i++) begin
      for (int w = 0; w < WIN_WORDS; w++) begin
        xfer(i, TB_BASE + 32'(w * 4), 1'b1, 4'b1111, $urandom, "fill");
      end
    end
  endtask

  task automatic test_ws1_write_read();
    xfer(0, 32'h0000_1000, 1'b1, 4'b1111, 32'hDEAD_BEEF, "ws1_write");
    xfer(0, 32'h0000_1000, 1'b0, 4'b1111, 32'h0, "ws1_read");
  endtask

  task automatic test_back_to_back();
    xfer(1, 32'h0000_0008, 1'b1, 4'b1111, 32'h1122_3344, "b2b_preload");
    b2b(32'h0000_0008, 4'b0010, 32'h0000_AB00, 1'b0, "b2b_lane1");
    for (int n = 0; n < 20; n++) begin
      logic [3:0] lm [7];
      lm = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111};
      b2b(TB_BASE + 32'($urandom_range(WIN_WORDS - 1, 0) * 4), lm[$urandom_range(6, 0)],
          $urandom, n[0], "b2b_random");
    end
  endtask

  task automatic test_error_range();
    for (int i = 0; i < 3; i++) begin
      xfer(i, TB_BASE + 32'(TB_DEPTH * 4), 1'b0, 4'b1111, 32'h0, "err_read_top");
      xfer(i, 32'hFFFF_FFFC, 1'b1, 4'b1111, $urandom, "err_write_high");
    end
  endtask

  task automatic test_error_mask();
    xfer(0, 32'h0000_0004, 1'b1, 4'b1111, 32'h5555_5555, "mask_preload");
    xfer(0, 32'h0000_0004, 1'b1, 4'b0110, 32'hAAAA_AAAA, "mask_illegal_write");
    xfer(0, 32'h0000_0004, 1'b0, 4'b1111, 32'h0, "mask_readback");
  endtask

  task automatic test_idle_busy();
    for (int c = 0; c < 6; c++) begin
      htrans[0] = (c < 3) ? HTRANS_BUSY : HTRANS_IDLE;
      addr[0] = 32'h0000_0004; wr[0] = 1'b1; mask[0] = 4'b1111; wdata[0] = $urandom;
      @(negedge clk);
      n_checks++;
      if (hready[0] !== 1'b1 || hresp[0] !== 1'b0 || rdata[0] !== 32'h0) begin
        n_fail++;
        $display("FAIL idle_busy[%0d]: hready=%0b hresp=%0b rdata=%08h, expected 1/0/00000000",
                 c, hready[0], hresp[0], rdata[0]);
      end
    end
    htrans[0] = HTRANS_IDLE;
    xfer(0, 32'h0000_0004, 1'b0, 4'b1111, 32'h0, "idle_busy_readback");
  endtask

  task automatic test_reset_abort();
    xfer(2, 32'h0000_0010, 1'b1, 4'b1111, 32'h0, "abort_preload");
    @(negedge clk);
    htrans[2] = HTRANS_NONSEQ; addr[2] = 32'h0000_0010; wr[2] = 1'b1; mask[2] = 4'b1111;
    @(negedge clk);
    htrans[2] = HTRANS_IDLE; wdata[2] = 32'hFFFF_FFFF;
    n_checks++;
    if (hready[2] !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_wait: hready=%0b expected=0", hready[2]);
    end
    #1 rst_n[2] = 1'b0;
    #1;
    n_checks++;
    if (hready[2] !== 1'b1 || hresp[2] !== 1'b0 || rdata[2] !== 32'h0) begin
      n_fail++;
      $display("FAIL abort_reset: hready=%0b hresp=%0b rdata=%08h, expected 1/0/00000000",
               hready[2], hresp[2], rdata[2]);
    end
    repeat (2) @(negedge clk);
    rst_n[2] = 1'b1;
    xfer(2, 32'h0000_0010, 1'b0, 4'b1111, 32'h0, "abort_readback");
  endtask

  task automatic test_random();
    for (int n = 0; n < 90; n++) begin
      int i;
      int r;
      logic [31:0] a;
      logic [3:0] m;
      logic [3:0] lm [7];
      lm = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111};
      i = $urandom_range(2, 0);
      r = $urandom_range(99, 0);
      if (r < 85)      a = TB_BASE + 32'($urandom_range(WIN_WORDS * 4 - 1, 0));
      else if (r < 93) a = TB_BASE + 32'(TB_DEPTH * 4) + 32'($urandom_range(255, 0) * 4);
      else             a = $urandom | 32'h8000_0000;
      m = ($urandom_range(9, 0) < 8) ? lm[$urandom_range(6, 0)] : 4'($urandom_range(15, 0));
      xfer(i, a, 1'($urandom), m, $urandom, "random");
    end
  endtask

  initial begin
    rst_n  = '0;
    htrans = '0;
    addr   = '0;
    wr     = '0;
    mask   = '0;
    wdata  = '0;
    test_reset();
    test_fill();
    test_ws1_write_read();
    test_back_to_back();
    test_error_range();
    test_error_mask();
    test_idle_busy();
    test_reset_abort();
    test_random();
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: bench did not finish by %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
